// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// LoadStoreUnit: initiator side of the data-memory interface, sitting between
// the MEM stage of the datapath and d_mem. It accepts one load or store at a
// time (byte, halfword or word, signed or unsigned). It drives the d_mem word
// address, write data and enables, and does read-modify-write for sub-word
// stores. Load data comes back aligned and extended, together with a one-cycle
// done pulse.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   req        in   core request, sampled only while idle
//   we         in   1 = store, 0 = load
//   size       in   00 byte, 01 halfword, 10 word, 11 illegal
//   uns        in   1 = zero-extend loads, 0 = sign-extend
//   addr       in   byte address
//   wdata      in   store data (low bits for sub-word stores)
//   busy       out  high whenever the unit is not idle
//   done       out  one-cycle completion pulse
//   err        out  fault flag, valid with done
//   rdata      out  load result, held until the next load completes
//   mem_addr   out  word index into d_mem
//   mem_wdata  out  word written to d_mem
//   mem_rdata  in   word read from d_mem (combinational in mem_addr)
//   MemRead    out  d_mem read enable
//   MemWrite   out  d_mem write enable
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned DEPTH      = 1024,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        MemRead,
  output logic        MemWrite
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_ERR,
    S_DONE
  } state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_we;
  logic        r_uns;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [15:0] r_wdataLo;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_outOfRange;
  logic        w_fault;
  logic        w_wordStore;
  logic [4:0]  w_byteShift;
  logic [4:0]  w_halfShift;
  logic [7:0]  w_loadByte;
  logic [15:0] w_loadHalf;
  logic [31:0] w_loadData;
  logic [31:0] w_mergeData;

  // Request qualification. The fault checks look at the live request so that
  // the unit can branch straight to ERR on the accepting edge.
  assign w_accept     = (r_state == S_IDLE) && req;
  assign w_misaligned = ((size == 2'b01) && addr[0]) ||
                        ((size == 2'b10) && (addr[1:0] != 2'b00));
  assign w_outOfRange = {1'b0, addr} >= ADDR_LIMIT;
  assign w_fault      = w_misaligned || (size == 2'b11) || w_outOfRange;
  assign w_wordStore  = we && (size == 2'b10);

  // Bit position of the addressed byte lane / halfword within the word.
  // In MIPS order lane 0 is the most significant byte, so the lane offset is
  // inverted before scaling.
  assign w_byteShift = BIG_ENDIAN ? {~r_off, 3'b000}    : {r_off, 3'b000};
  assign w_halfShift = BIG_ENDIAN ? {~r_off[1], 4'b0000} : {r_off[1], 4'b0000};
  assign w_loadByte  = 8'(mem_rdata >> w_byteShift);
  assign w_loadHalf  = 16'(mem_rdata >> w_halfShift);

  // Load result: pick the addressed lane(s) out of the word being read and
  // extend to 32 bits. Word loads pass straight through.
  always_comb begin
    w_loadData = mem_rdata;
    case (r_size)
      2'b00:   w_loadData = {{24{w_loadByte[7] & ~r_uns}}, w_loadByte};
      2'b01:   w_loadData = {{16{w_loadHalf[15] & ~r_uns}}, w_loadHalf};
      default: w_loadData = mem_rdata;
    endcase
  end

  // Read-modify-write merge for sub-word stores: clear the addressed lane(s)
  // of the word just read and drop in the low store bits. Other bytes keep
  // their current memory contents.
  always_comb begin
    w_mergeData = mem_rdata;
    if (r_size == 2'b00) begin
      w_mergeData = (mem_rdata & ~(32'h0000_00FF << w_byteShift)) |
                    ({24'd0, r_wdataLo[7:0]} << w_byteShift);
    end else begin
      w_mergeData = (mem_rdata & ~(32'h0000_FFFF << w_halfShift)) |
                    ({16'd0, r_wdataLo} << w_halfShift);
    end
  end

  // State register. Reset from any state returns to IDLE; an operation in
  // flight is simply dropped, so nothing is written and no done is produced.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Word stores skip the read, sub-word stores read first
  // so they can merge, and loads finish straight after the read.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fault) begin
            w_nextState = S_ERR;
          end else if (w_wordStore) begin
            w_nextState = S_WR;
          end else begin
            w_nextState = S_RD;
          end
        end
      end
      S_RD:    w_nextState = r_we ? S_WR : S_DONE;
      S_WR:    w_nextState = S_DONE;
      S_ERR:   w_nextState = S_IDLE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Status and memory enables are registered from the next state. They
  // therefore line up with the state they describe and are glitch-free into
  // d_mem. RD and WR are distinct states, so MemRead and MemWrite can never
  // overlap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
    end else begin
      busy     <= (w_nextState != S_IDLE);
      done     <= (w_nextState == S_DONE) || (w_nextState == S_ERR);
      err      <= (w_nextState == S_ERR);
      MemRead  <= (w_nextState == S_RD);
      MemWrite <= (w_nextState == S_WR);
    end
  end

  // Request capture and datapath registers. The word address is latched at
  // acceptance and then held through RD and WR. rdata is written on the edge
  // that enters DONE, which is the same edge that ends the read. The word
  // read is therefore used directly and is not kept in a separate holding
  // register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_size    <= 2'b00;
      r_off     <= 2'b00;
      r_wdataLo <= 16'd0;
      rdata     <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_we      <= we;
        r_uns     <= uns;
        r_size    <= size;
        r_off     <= addr[1:0];
        r_wdataLo <= wdata[15:0];
        mem_addr  <= {2'b00, addr[31:2]};
        if (w_wordStore && !w_fault) begin
          mem_wdata <= wdata;
        end
      end
      if (r_state == S_RD) begin
        if (r_we) begin
          mem_wdata <= w_mergeData;
        end else begin
          rdata <= w_loadData;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// Testbench for load_store_unit. It runs directed cases and then randomized
// loads and stores against a byte-addressed reference model of memory. Every
// accepted request pushes its expected response into a queue. A monitor pops
// that queue on each done pulse and compares the actual response against it.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wordIdx;
    int          acceptCyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic        uns   = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memRead;
  logic        memWrite;

  logic [31:0] dmem [0:1023];
  logic        fillReq   = 1'b1;
  logic        presetEn  = 1'b0;
  logic [9:0]  presetIdx = 10'd0;
  logic [31:0] presetVal = 32'd0;

  logic [7:0]  refBytes [0:4095];
  logic [31:0] lastRdata = 32'd0;
  exp_t        q[$];
  exp_t        monE;

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int acceptCount = 0;
  int doneCount   = 0;
  int opRd        = 0;
  int opWr        = 0;
  int opBoth      = 0;
  int opBadAddr   = 0;

  load_store_unit #(
    .DEPTH      (1024),
    .BIG_ENDIAN (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .uns       (uns),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_rdata (memRdata),
    .MemRead   (memRead),
    .MemWrite  (memWrite)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // d_mem stand-in. It reads combinationally and writes on the clock. A
  // single writer also handles the initial random fill and any word presets.
  assign memRdata = (memAddr < 32'd1024) ? dmem[memAddr[9:0]] : 32'd0;

  always @(posedge clock) begin
    if (fillReq) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= $urandom;
    end else if (presetEn) begin
      dmem[presetIdx] <= presetVal;
    end else if (memWrite && (memAddr < 32'd1024)) begin
      dmem[memAddr[9:0]] <= memWdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Reference model. Memory is treated as a flat array of bytes in MIPS
  // order: the lowest address holds the most significant byte of a value.
  function automatic exp_t modelOp(input logic w, input logic [1:0] sz, input logic u,
                                   input logic [31:0] a, input logic [31:0] d);
    exp_t   e;
    int     n;
    int     base;
    longint v;
    logic   fault;
    e.wordIdx   = {2'b00, a[31:2]};
    e.acceptCyc = 0;
    fault = (sz == 2'b11) || (a >= 32'd4096) ||
            ((sz == 2'b01) && (a % 2 != 0)) || ((sz == 2'b10) && (a % 4 != 0));
    if (fault) begin
      e.err = 1'b1; e.lat = 1; e.rd = 0; e.wr = 0;
    end else begin
      n    = 1 << sz;
      base = int'(a);
      e.err = 1'b0;
      if (!w) begin
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | longint'(refBytes[base + i]);
        if (!u && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
        lastRdata = 32'(v);
        e.lat = 2; e.rd = 1; e.wr = 0;
      end else begin
        for (int i = 0; i < n; i++) refBytes[base + i] = 8'(d >> (8 * (n - 1 - i)));
        e.lat = (n == 4) ? 2 : 3;
        e.rd  = (n == 4) ? 0 : 1;
        e.wr  = 1;
      end
    end
    e.rdata = lastRdata;
    return e;
  endfunction

  // Wait, bounded, until the unit is idle at a falling edge. While it is busy,
  // req is optionally pulsed with random junk, which the unit must ignore.
  task automatic waitIdle(input bit junk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (!busy) begin
        req = 1'b0;
        return;
      end
      req = junk && ($urandom_range(0, 2) == 0);
      if (req) begin
        we    = 1'($urandom);
        size  = 2'($urandom);
        uns   = 1'($urandom);
        addr  = 32'($urandom_range(0, 63));
        wdata = $urandom;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL idle_timeout: busy still 1 after 40 cycles, expected 0");
  endtask

  // Present one request on an idle falling edge and queue its expected response.
  task automatic applyStimulus(input logic iWe, input logic [1:0] iSize, input logic iUns,
                               input logic [31:0] iAddr, input logic [31:0] iWdata, input bit junk);
    exp_t e;
    waitIdle(junk);
    req   = 1'b1;
    we    = iWe;
    size  = iSize;
    uns   = iUns;
    addr  = iAddr;
    wdata = iWdata;
    e = modelOp(iWe, iSize, iUns, iAddr, iWdata);
    e.acceptCyc = cyc;
    q.push_back(e);
    acceptCount++;
  endtask

  task automatic presetWord(input int idx, input logic [31:0] val);
    waitIdle(1'b0);
    presetIdx = 10'(idx);
    presetVal = val;
    presetEn  = 1'b1;
    @(negedge clock);
    presetEn = 1'b0;
    for (int j = 0; j < 4; j++) refBytes[4 * idx + j] = 8'(val >> (8 * (3 - j)));
  endtask

  // Monitor: count memory cycles per operation and check each done pulse
  // against the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      opRd = 0; opWr = 0; opBoth = 0; opBadAddr = 0;
    end else begin
      if (memRead) opRd++;
      if (memWrite) opWr++;
      if (memRead && memWrite) opBoth++;
      if ((memRead || memWrite) && q.size() > 0 && memAddr !== q[0].wordIdx) opBadAddr++;
      if (done) begin
        doneCount++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_done: done=1 with no request outstanding, expected 0");
        end else begin
          monE = q.pop_front();
          checkOutput("err", {31'd0, err}, {31'd0, monE.err});
          checkOutput("rdata", rdata, monE.rdata);
          checkOutput("latency", 32'(cyc - monE.acceptCyc), 32'(monE.lat));
          checkOutput("read_cycles", 32'(opRd), 32'(monE.rd));
          checkOutput("write_cycles", 32'(opWr), 32'(monE.wr));
          checkOutput("rw_overlap", 32'(opBoth), 32'd0);
          checkOutput("mem_addr", 32'(opBadAddr), 32'd0);
        end
        opRd = 0; opWr = 0; opBoth = 0; opBadAddr = 0;
      end
    end
  end

  initial begin
    int          base;
    int          bad;
    int          firstBad;
    logic [31:0] wexp;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;

    // Reset, fill memory randomly, then mirror it into the byte model.
    repeat (3) @(posedge clock);
    fillReq = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 1024; i++)
      for (int j = 0; j < 4; j++) refBytes[4 * i + j] = 8'(dmem[i] >> (8 * (3 - j)));
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_memread", {31'd0, memRead}, 32'd0);
    checkOutput("rst_memwrite", {31'd0, memWrite}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_mem_addr", memAddr, 32'd0);
    checkOutput("rst_mem_wdata", memWdata, 32'd0);
    reset = 1'b1;

    // Word store followed by a word load of the same address.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    waitIdle(1'b0);
    checkOutput("sw_word4", dmem[4], 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    waitIdle(1'b0);
    checkOutput("lw_rdata", rdata, 32'hDEADBEEF);

    // Byte store merge into a known word, then extension cases.
    presetWord(4, 32'h11223344);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 1'b0);
    waitIdle(1'b0);
    checkOutput("sb_merge", dmem[4], 32'h11AA3344);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0);
    waitIdle(1'b0);
    checkOutput("lb_rdata", rdata, 32'hFFFFFFAA);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0);
    waitIdle(1'b0);
    checkOutput("lbu_rdata", rdata, 32'h000000AA);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0);
    waitIdle(1'b0);
    checkOutput("lh_rdata", rdata, 32'h00003344);

    // Faults: misaligned word, misaligned half, illegal size, out of range.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'd4096, 32'h0, 1'b0);
    waitIdle(1'b0);
    checkOutput("fault_rdata_held", rdata, 32'h00003344);
    checkOutput("fault_mem_untouched", dmem[4], 32'h11AA3344);

    // Reset during the read half of a byte store: nothing is written and the
    // unit comes back fully cleared.
    waitIdle(1'b0);
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h11; wdata = 32'h55;
    @(negedge clock);
    req = 1'b0;
    checkOutput("rst_mid_rd_cycle", {31'd0, memRead}, 32'd1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    lastRdata = 32'd0;
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_done", {31'd0, done}, 32'd0);
    checkOutput("rst_mid_err", {31'd0, err}, 32'd0);
    checkOutput("rst_mid_memread", {31'd0, memRead}, 32'd0);
    checkOutput("rst_mid_memwrite", {31'd0, memWrite}, 32'd0);
    checkOutput("rst_mid_rdata", rdata, 32'd0);
    checkOutput("rst_mid_mem_addr", memAddr, 32'd0);
    checkOutput("rst_mid_mem_wdata", memWdata, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    checkOutput("rst_mid_nowrite", dmem[4], 32'h11AA3344);

    // Back-to-back operations with junk requests while busy.
    base = doneCount;
    for (int k = 0; k < 5; k++)
      applyStimulus(1'($urandom), 2'($urandom_range(0, 2)) & 2'b00, 1'($urandom),
                    32'($urandom_range(0, 63)), $urandom, 1'b1);
    waitIdle(1'b0);
    checkOutput("busy_filter_dones", 32'(doneCount - base), 32'd5);

    // Randomized traffic, including the top-of-memory boundary.
    for (int k = 0; k < 400; k++) begin
      r  = int'($urandom_range(0, 15));
      sz = (r == 0) ? 2'b11 : 2'(r % 3);
      r  = int'($urandom_range(0, 19));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'($urandom_range(4088, 4103));
      else             a = 32'($urandom_range(0, 63));
      applyStimulus(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
    end
    waitIdle(1'b0);

    // Final bookkeeping and full memory image comparison.
    checkOutput("queue_drained", 32'(q.size()), 32'd0);
    checkOutput("done_per_accept", 32'(doneCount), 32'(acceptCount));
    bad = 0;
    firstBad = -1;
    for (int i = 0; i < 1024; i++) begin
      wexp = {refBytes[4 * i], refBytes[4 * i + 1], refBytes[4 * i + 2], refBytes[4 * i + 3]};
      if (dmem[i] !== wexp) begin
        bad++;
        if (firstBad < 0) firstBad = i;
      end
    end
    if (bad != 0) $display("[TB] first differing memory word index %0d", firstBad);
    checkOutput("mem_image", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
